// File: rtl/bp_me_pkg.sv
// Shared types for the DRAM DMA stage: FSM state encoding and counter sizing.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_cmd   = 2'd1,
    e_wdata = 2'd2,
    e_rdata = 2'd3
  } dma_state_e;

  // A single-beat block still needs a 1-bit counter so the register is never zero-width.
  function automatic int unsigned beat_cnt_width(input int unsigned beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/bp_me_dram_hash_decode.sv
// Un-swizzles an L2-hashed address [tag][bank][slice][cce][set][block]
// into DRAM order [tag][set][bank][slice][cce][block].
module bp_me_dram_hash_decode #(
  parameter int unsigned daddr_width_p    = 40,
  parameter int unsigned l2_block_width_p = 512,
  parameter int unsigned num_cce_p        = 1,
  parameter int unsigned l2_slices_p      = 1,
  parameter int unsigned l2_banks_p       = 1,
  parameter int unsigned l2_sets_p        = 64
) (
  input  logic [daddr_width_p-1:0] daddr_i,
  output logic [daddr_width_p-1:0] daddr_o
);

  localparam int unsigned block_w_lp = $clog2(l2_block_width_p / 8);
  localparam int unsigned set_w_lp   = $clog2(l2_sets_p);
  localparam int unsigned cce_w_lp   = $clog2(num_cce_p);
  localparam int unsigned slice_w_lp = $clog2(l2_slices_p);
  localparam int unsigned bank_w_lp  = $clog2(l2_banks_p);

  // Shift/mask extraction so that fields with a count of 1 collapse to nothing.
  function automatic logic [daddr_width_p-1:0] low_bits(input logic [daddr_width_p-1:0] v,
                                                         input int unsigned w);
    logic [daddr_width_p-1:0] mask;
    mask = '1;
    mask = mask >> (daddr_width_p - w);
    return v & mask;
  endfunction

  logic [daddr_width_p-1:0] rest, blk, set, cce, slice, bank, tag, out;

  always_comb begin
    blk   = low_bits(daddr_i, block_w_lp);
    rest  = daddr_i >> block_w_lp;
    set   = low_bits(rest, set_w_lp);
    rest  = rest >> set_w_lp;
    cce   = low_bits(rest, cce_w_lp);
    rest  = rest >> cce_w_lp;
    slice = low_bits(rest, slice_w_lp);
    rest  = rest >> slice_w_lp;
    bank  = low_bits(rest, bank_w_lp);
    tag   = rest >> bank_w_lp;

    out = tag;
    out = (out << set_w_lp)   | set;
    out = (out << bank_w_lp)  | bank;
    out = (out << slice_w_lp) | slice;
    out = (out << cce_w_lp)   | cce;
    out = (out << block_w_lp) | blk;
    daddr_o = out;
  end

endmodule

// File: rtl/bp_me_dram_dma_stage.sv
// Single-outstanding DMA-to-DRAM bridge: one command, then one block of
// write or read beats passed straight through.
module bp_me_dram_dma_stage
  import bp_me_pkg::*;
#(
  parameter int unsigned daddr_width_p    = 40,
  parameter int unsigned l2_block_width_p = 512,
  parameter int unsigned num_cce_p        = 1,
  parameter int unsigned l2_slices_p      = 1,
  parameter int unsigned l2_banks_p       = 1,
  parameter int unsigned l2_sets_p        = 64,
  parameter int unsigned dma_data_width_p = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [daddr_width_p:0]      dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_ready_and_o,
  input  logic [dma_data_width_p-1:0] dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_ready_and_o,
  output logic [dma_data_width_p-1:0] dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_and_i,
  output logic [daddr_width_p-1:0]    dram_cmd_addr_o,
  output logic                        dram_cmd_we_o,
  output logic                        dram_cmd_v_o,
  input  logic                        dram_cmd_ready_and_i,
  output logic [dma_data_width_p-1:0] dram_wdata_o,
  output logic                        dram_wdata_v_o,
  input  logic                        dram_wdata_ready_and_i,
  input  logic [dma_data_width_p-1:0] dram_rdata_i,
  input  logic                        dram_rdata_v_i,
  output logic                        dram_rdata_ready_and_o
);

  localparam int unsigned beats_lp        = l2_block_width_p / dma_data_width_p;
  localparam int unsigned block_offset_lp = $clog2(l2_block_width_p / 8);
  localparam int unsigned cnt_w_lp        = beat_cnt_width(beats_lp);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(beats_lp - 1);

  dma_state_e state_q, state_d;
  logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
  logic [daddr_width_p-1:0] addr_q, addr_d;
  logic                     we_q, we_d;
  logic [daddr_width_p-1:0] dec_addr, aligned_addr;
  logic                     beat_hs;

  bp_me_dram_hash_decode #(
    .daddr_width_p   (daddr_width_p),
    .l2_block_width_p(l2_block_width_p),
    .num_cce_p       (num_cce_p),
    .l2_slices_p     (l2_slices_p),
    .l2_banks_p      (l2_banks_p),
    .l2_sets_p       (l2_sets_p)
  ) u_decode (
    .daddr_i(dma_pkt_i[daddr_width_p-1:0]),
    .daddr_o(dec_addr)
  );

  assign aligned_addr = (dec_addr >> block_offset_lp) << block_offset_lp;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  assign dram_cmd_addr_o = addr_q;
  assign dram_cmd_we_o   = we_q;

  always_comb begin
    state_d                = state_q;
    cnt_d                  = cnt_q;
    addr_d                 = addr_q;
    we_d                   = we_q;
    beat_hs                = 1'b0;
    dma_pkt_ready_and_o    = 1'b0;
    dram_cmd_v_o           = 1'b0;
    dram_wdata_v_o         = 1'b0;
    dma_data_ready_and_o   = 1'b0;
    dma_data_v_o           = 1'b0;
    dram_rdata_ready_and_o = 1'b0;
    dram_wdata_o           = dma_data_i;
    dma_data_o             = dram_rdata_i;

    unique case (state_q)
      e_idle: begin
        // Ready is gated by reset so nothing is offered while reset is held.
        dma_pkt_ready_and_o = ~reset_i;
        if (dma_pkt_v_i && !reset_i) begin
          addr_d  = aligned_addr;
          we_d    = dma_pkt_i[daddr_width_p];
          cnt_d   = '0;
          state_d = e_cmd;
        end
      end
      e_cmd: begin
        dram_cmd_v_o = 1'b1;
        if (dram_cmd_ready_and_i) state_d = we_q ? e_wdata : e_rdata;
      end
      e_wdata: begin
        dram_wdata_v_o       = dma_data_v_i;
        dma_data_ready_and_o = dram_wdata_ready_and_i;
        beat_hs              = dma_data_v_i & dram_wdata_ready_and_i;
      end
      e_rdata: begin
        dma_data_v_o           = dram_rdata_v_i;
        dram_rdata_ready_and_o = dma_data_ready_and_i;
        beat_hs                = dram_rdata_v_i & dma_data_ready_and_i;
      end
      default: state_d = e_idle;
    endcase

    if (beat_hs) begin
      if (cnt_q == last_cnt_lp) begin
        cnt_d   = '0;
        state_d = e_idle;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_me_dram_dma_stage.sv
// Directed bench: banked-config DUT for transactions, default-config DUT for identity decode.
module tb_bp_me_dram_dma_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [40:0] dma_pkt_i;
  logic        dma_pkt_v_i, dma_pkt_ready_and_o;
  logic [63:0] dma_data_i, dma_data_o, dram_wdata_o, dram_rdata_i;
  logic        dma_data_v_i, dma_data_ready_and_o, dma_data_v_o, dma_data_ready_and_i;
  logic [39:0] dram_cmd_addr_o;
  logic        dram_cmd_we_o, dram_cmd_v_o, dram_cmd_ready_and_i;
  logic        dram_wdata_v_o, dram_wdata_ready_and_i, dram_rdata_v_i, dram_rdata_ready_and_o;

  logic [40:0] pkt_b;
  logic        pkt_v_b, pkt_rdy_b, dready_b, dv_b, cmd_we_b, cmd_v_b, wv_b, rrdy_b;
  logic [63:0] d_b, wd_b;
  logic [39:0] addr_b;

  int checks   = 0;
  int failures = 0;

  bp_me_dram_dma_stage #(
    .daddr_width_p(40), .l2_block_width_p(512), .num_cce_p(1),
    .l2_slices_p(1), .l2_banks_p(2), .l2_sets_p(128), .dma_data_width_p(64)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_ready_and_o(dma_pkt_ready_and_o),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_ready_and_o(dma_data_ready_and_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_ready_and_i),
    .dram_cmd_addr_o(dram_cmd_addr_o), .dram_cmd_we_o(dram_cmd_we_o), .dram_cmd_v_o(dram_cmd_v_o),
    .dram_cmd_ready_and_i(dram_cmd_ready_and_i),
    .dram_wdata_o(dram_wdata_o), .dram_wdata_v_o(dram_wdata_v_o), .dram_wdata_ready_and_i(dram_wdata_ready_and_i),
    .dram_rdata_i(dram_rdata_i), .dram_rdata_v_i(dram_rdata_v_i), .dram_rdata_ready_and_o(dram_rdata_ready_and_o)
  );

  bp_me_dram_dma_stage dut_def (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(pkt_b), .dma_pkt_v_i(pkt_v_b), .dma_pkt_ready_and_o(pkt_rdy_b),
    .dma_data_i(64'h0), .dma_data_v_i(1'b0), .dma_data_ready_and_o(dready_b),
    .dma_data_o(d_b), .dma_data_v_o(dv_b), .dma_data_ready_and_i(1'b0),
    .dram_cmd_addr_o(addr_b), .dram_cmd_we_o(cmd_we_b), .dram_cmd_v_o(cmd_v_b),
    .dram_cmd_ready_and_i(1'b0),
    .dram_wdata_o(wd_b), .dram_wdata_v_o(wv_b), .dram_wdata_ready_and_i(1'b0),
    .dram_rdata_i(64'h0), .dram_rdata_v_i(1'b0), .dram_rdata_ready_and_o(rrdy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic read_beats(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      dram_rdata_v_i       = 1'b1;
      dram_rdata_i         = base | 64'(i);
      dma_data_ready_and_i = 1'b1;
      #1;
      chk("rd_v", {63'b0, dma_data_v_o}, 64'd1);
      chk("rd_data", dma_data_o, base | 64'(i));
      chk("rd_rdy", {63'b0, dram_rdata_ready_and_o}, 64'd1);
      chk("rd_pkt_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd0);
      chk("rd_no_wv", {63'b0, dram_wdata_v_o}, 64'd0);
      cyc();
    end
  endtask

  initial begin
    int hs;
    int c;
    logic wr;
    reset_i = 1'b1;
    dma_pkt_i = '0; dma_pkt_v_i = 1'b0;
    dma_data_i = '0; dma_data_v_i = 1'b0; dma_data_ready_and_i = 1'b0;
    dram_cmd_ready_and_i = 1'b0; dram_wdata_ready_and_i = 1'b0;
    dram_rdata_i = '0; dram_rdata_v_i = 1'b0;
    pkt_b = '0; pkt_v_b = 1'b0;

    // Reset state
    #3;
    chk("rst_pkt_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd0);
    chk("rst_cmd_v", {63'b0, dram_cmd_v_o}, 64'd0);
    chk("rst_addr", {24'b0, dram_cmd_addr_o}, 64'd0);
    cyc();
    reset_i = 1'b0;
    #1;
    chk("post_rst_pkt_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd1);

    // Default config: identity decode plus block alignment
    pkt_b = {1'b0, 40'h80_0000_1234};
    pkt_v_b = 1'b1;
    // Read 0x2000 on banked config
    dma_pkt_i = {1'b0, 40'h2000};
    dma_pkt_v_i = 1'b1;
    cyc();
    pkt_v_b = 1'b0;
    dma_pkt_v_i = 1'b0;
    dram_rdata_v_i = 1'b1;
    #1;
    chk("def_addr", {24'b0, addr_b}, 64'h80_0000_1200);
    chk("def_cmd_v", {63'b0, cmd_v_b}, 64'd1);
    chk("rd1_cmd_v", {63'b0, dram_cmd_v_o}, 64'd1);
    chk("rd1_addr", {24'b0, dram_cmd_addr_o}, 64'h40);
    chk("rd1_we", {63'b0, dram_cmd_we_o}, 64'd0);
    chk("rd1_pkt_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd0);
    chk("cmd_no_rv", {63'b0, dma_data_v_o}, 64'd0);
    dram_cmd_ready_and_i = 1'b1;
    cyc();
    dram_cmd_ready_and_i = 1'b0;
    read_beats(8, 64'hD000_0000_0000_0000);
    #1;
    chk("rd1_done_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd1);
    chk("idle_no_rv", {63'b0, dma_data_v_o}, 64'd0);
    chk("idle_no_rrdy", {63'b0, dram_rdata_ready_and_o}, 64'd0);

    // Write 0x47, command stalled 5 cycles with a second packet waiting
    dma_pkt_i = {1'b1, 40'h47};
    dma_pkt_v_i = 1'b1;
    cyc();
    dma_pkt_i = {1'b0, 40'h2040};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("wr_stall_cmd_v", {63'b0, dram_cmd_v_o}, 64'd1);
      chk("wr_stall_addr", {24'b0, dram_cmd_addr_o}, 64'h80);
      chk("wr_stall_we", {63'b0, dram_cmd_we_o}, 64'd1);
      chk("wr_stall_pkt_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd0);
      cyc();
    end
    dram_cmd_ready_and_i = 1'b1;
    cyc();
    dram_cmd_ready_and_i = 1'b0;

    // Write beats with DRAM ready toggling 1,0,1,0...
    hs = 0;
    for (c = 0; hs < 8 && c < 30; c++) begin
      wr = (c % 2 == 0);
      dma_data_v_i = 1'b1;
      dma_data_i = 64'hA5A5_0000_0000_0000 | 64'(hs);
      dram_wdata_ready_and_i = wr;
      #1;
      chk("wr_v", {63'b0, dram_wdata_v_o}, 64'd1);
      chk("wr_data", dram_wdata_o, 64'hA5A5_0000_0000_0000 | 64'(hs));
      chk("wr_rdy", {63'b0, dma_data_ready_and_o}, {63'b0, wr});
      chk("wr_no_rv", {63'b0, dma_data_v_o}, 64'd0);
      chk("wr_pkt_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd0);
      cyc();
      if (wr) hs++;
    end
    chk("wr_beats", 64'(hs), 64'd8);
    chk("wr_cycles", 64'(c), 64'd15);
    dram_wdata_ready_and_i = 1'b1;
    #1;
    chk("wr_done_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd1);
    chk("idle_no_wv", {63'b0, dram_wdata_v_o}, 64'd0);
    chk("idle_no_wrdy", {63'b0, dma_data_ready_and_o}, 64'd0);

    // Waiting packet (read 0x2040 -> set 1, bank 1 -> 0xC0) now accepted
    cyc();
    dma_pkt_v_i = 1'b0;
    dma_data_v_i = 1'b0;
    dram_wdata_ready_and_i = 1'b0;
    #1;
    chk("rd2_addr", {24'b0, dram_cmd_addr_o}, 64'hC0);
    chk("rd2_we", {63'b0, dram_cmd_we_o}, 64'd0);
    dram_cmd_ready_and_i = 1'b1;
    cyc();
    dram_cmd_ready_and_i = 1'b0;
    read_beats(3, 64'hB000_0000_0000_0000);

    // Asynchronous reset mid-read
    reset_i = 1'b1;
    #1;
    chk("arst_rv", {63'b0, dma_data_v_o}, 64'd0);
    chk("arst_rrdy", {63'b0, dram_rdata_ready_and_o}, 64'd0);
    chk("arst_pkt_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd0);
    chk("arst_addr", {24'b0, dram_cmd_addr_o}, 64'd0);
    chk("arst_cmd_v", {63'b0, dram_cmd_v_o}, 64'd0);
    cyc();
    reset_i = 1'b0;
    dram_rdata_v_i = 1'b0;
    #1;
    chk("arst_rel_pkt_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd1);

    // Fresh read after reset gets a full block
    dma_pkt_i = {1'b0, 40'h2000};
    dma_pkt_v_i = 1'b1;
    cyc();
    dma_pkt_v_i = 1'b0;
    #1;
    chk("rd3_addr", {24'b0, dram_cmd_addr_o}, 64'h40);
    chk("rd3_cmd_v", {63'b0, dram_cmd_v_o}, 64'd1);
    dram_cmd_ready_and_i = 1'b1;
    cyc();
    dram_cmd_ready_and_i = 1'b0;
    read_beats(8, 64'hC000_0000_0000_0000);
    #1;
    chk("rd3_done_rdy", {63'b0, dma_pkt_ready_and_o}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
